// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake feeding the loader and the instruction
//   memory write port it drives.
//
//   Ports / signals:
//     in_data      [7:0]            stream byte
//     in_valid                      in_data valid
//     in_ready                      loader accepts the byte this cycle
//     imem_wr_en                    IMEM write strobe, one cycle per word
//     imem_wr_addr [PC_WIDTH-1:0]   IMEM byte address, word aligned
//     imem_wr_data [INST_WIDTH-1:0] packed word, first received byte in [7:0]
//
//   Modports:
//     master : the loader side (drives in_ready and the IMEM write port)
//     slave  : the environment side (byte source and IMEM)
interface imem_loader_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_wr_en;
    logic [PC_WIDTH-1:0]   imem_wr_addr;
    logic [INST_WIDTH-1:0] imem_wr_data;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader: parses a framed image from a byte stream
//   (sync byte, 16-bit little-endian word count, little-endian instruction
//   bytes), packs bytes into 32-bit words and writes them to consecutive
//   word addresses of the instruction memory. Holds the core in stall until
//   the image is complete and flags malformed frames.
//
//   Optional build macro: IMEM_LOADER_CHKSUM_EN
//     When defined, a trailing XOR checksum byte follows the data and is
//     verified in the CHK state before DONE.
//
//   Ports:
//     clk           system clock
//     reset_n       asynchronous active-low reset
//     load_restart  one-cycle pulse: abort any load, return to SYNC
//     bus           imem_loader_if.master (byte stream + IMEM write port)
//     cpu_hold      stall core fetch while high
//     load_done     image fully written
//     load_err      frame error, held until load_restart or reset
//     word_cnt      words written so far in the current frame
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SYNC  | hunting for SYNC_BYTE, other bytes discarded
//   LEN0  | expecting word count [7:0]
//   LEN1  | expecting word count [15:8], range-checked here
//   DATA  | collecting instruction bytes, one IMEM write per 4 bytes
//   CHK   | expecting checksum byte (checksum build only)
//   DONE  | image complete, core released, stream stalled
//   ERR   | malformed frame, stream stalled until load_restart
module imem_loader #(
    parameter int         PC_WIDTH   = 32,
    parameter int         INST_WIDTH = 32,
    parameter int         IMEM_DEPTH = 1024,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_restart,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [15:0]   word_cnt
);

    localparam logic [16:0] MAX_WORDS = 17'(IMEM_DEPTH / 4);

`ifdef IMEM_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    state_t                state;
    state_t                state_nxt;

    logic                  in_ready_c;
    logic                  load_err_c;
    logic                  accept;
    logic                  word_fire;
    logic [15:0]           word_cnt_inc;
    logic [15:0]           len_in;

    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [7:0]            len_lo;
    logic [15:0]           len_full;
    logic                  wr_en_q;
    logic [PC_WIDTH-1:0]   wr_addr_q;
    logic [INST_WIDTH-1:0] wr_data_q;
    logic                  done_q;
    logic [15:0]           cnt_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]            chk_xor;
`endif

    assign accept       = bus.in_valid && in_ready_c;
    assign word_fire    = accept && (state == S_DATA) && (byte_idx == 2'd3);
    assign word_cnt_inc = cnt_q + 16'd1;
    assign len_in       = {bus.in_data, len_lo};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b1;
        load_err_c = 1'b0;

        case (state)
            S_DONE: in_ready_c = 1'b0;
            S_ERR: begin
                in_ready_c = 1'b0;
                load_err_c = 1'b1;
            end
            default: ;
        endcase

        if (load_restart) begin
            // Restart beats any byte offered in the same cycle.
            state_nxt = S_SYNC;
        end else if (bus.in_valid && in_ready_c) begin
            case (state)
                S_SYNC: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        state_nxt = S_LEN0;
                    end
                end
                S_LEN0: state_nxt = S_LEN1;
                S_LEN1: begin
                    if (len_in == 16'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_DONE;
`endif
                    end else if ({1'b0, len_in} > MAX_WORDS) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    // Leave on the byte that completes the last word so the
                    // state change lines up with its write strobe.
                    if ((byte_idx == 2'd3) && (word_cnt_inc == len_full)) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (bus.in_data == chk_xor) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Datapath: length capture, byte packing, registered IMEM write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx  <= 2'd0;
            word_buf  <= 24'd0;
            len_lo    <= 8'd0;
            len_full  <= 16'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            cnt_q     <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_xor   <= 8'd0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (load_restart) begin
                byte_idx <= 2'd0;
                word_buf <= 24'd0;
                done_q   <= 1'b0;
                cnt_q    <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
                chk_xor  <= 8'd0;
`endif
            end else begin
                // Asserted one cycle after the final write (or after DONE
                // is entered directly for an empty image).
                if (state == S_DONE) begin
                    done_q <= 1'b1;
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                if (state == S_SYNC) begin
                    chk_xor <= 8'd0;
                end
`endif
                if (accept) begin
                    case (state)
                        S_SYNC: begin
                            if (bus.in_data == SYNC_BYTE) begin
                                byte_idx <= 2'd0;
                                cnt_q    <= 16'd0;
                            end
                        end
                        S_LEN0: len_lo <= bus.in_data;
                        S_LEN1: len_full <= len_in;
                        S_DATA: begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            chk_xor <= chk_xor ^ bus.in_data;
`endif
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= bus.in_data;
                                2'd1: word_buf[15:8]  <= bus.in_data;
                                2'd2: word_buf[23:16] <= bus.in_data;
                                default: ;
                            endcase
                            if (word_fire) begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= INST_WIDTH'({bus.in_data, word_buf});
                                wr_addr_q <= PC_WIDTH'({cnt_q, 2'b00});
                                cnt_q     <= word_cnt_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign load_done        = done_q;
    assign load_err         = load_err_c;
    assign cpu_hold         = ~done_q;
    assign word_cnt         = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. A reference model builds each frame
//   as a byte list, derives the expected IMEM writes and final status from
//   the frame rules, and compares against the writes collected from the bus.
module tb_imem_loader;
    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;
    localparam int IMEM_DEPTH = 1024;
    localparam int MAX_WORDS  = IMEM_DEPTH / 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_restart = 1'b0;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_cnt;

    imem_loader_if #(.PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) bus ();

    imem_loader #(
        .PC_WIDTH  (PC_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .IMEM_DEPTH(IMEM_DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_restart(load_restart),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write collector
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          cyc = 0;
    int          last_wr_cyc = -100;
    int          done_cyc = -100;
    int          dbl_wr = 0;
    logic        prev_en = 1'b0;
    logic        prev_done = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.imem_wr_en === 1'b1) begin
                obs_addr.push_back(bus.imem_wr_addr);
                obs_data.push_back(bus.imem_wr_data);
                last_wr_cyc = cyc;
                if (prev_en) dbl_wr++;
            end
            if (load_done === 1'b1 && !prev_done) done_cyc = cyc;
            prev_en   = bus.imem_wr_en;
            prev_done = load_done;
        end
    end

    // Stimulus helpers
    logic [7:0] pre[$];
    logic [7:0] pay[$];

    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int n;
        int gap;
        n = 0;
        gap = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2) ? 1 : 0);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        load_restart = 1'b1;
        @(negedge clk);
        load_restart = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        dbl_wr      = 0;
        done_cyc    = -100;
        last_wr_cyc = -100;
    endtask

    task automatic rand_pay(input int words);
        pay.delete();
        for (int i = 0; i < words * 4; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic rand_pre(input int n);
        logic [7:0] b;
        pre.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            pre.push_back(b);
        end
    endtask

    // Sends pre, header, pay (and checksum in that build); checks against model.
    task automatic run_frame(input string tag, input int len, input int gap_mode, input bit bad_chk);
        logic [15:0] l16;
        logic [7:0]  x;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        int          n;
        bit          expect_err;

        l16 = 16'(len);
        pulse_restart();
        check({tag, "/rst_err"}, load_err, 0);
        check({tag, "/rst_hold"}, cpu_hold, 1);
        check({tag, "/rst_cnt"}, word_cnt, 0);

        x = 8'h00;
        if (len <= MAX_WORDS) begin
            for (int w = 0; w < len; w++) begin
                exp_addr.push_back(32'(4 * w));
                exp_data.push_back({pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]});
            end
            foreach (pay[i]) x = x ^ pay[i];
        end

        foreach (pre[i]) send_byte(pre[i], gap_mode);
        send_byte(8'hA5, gap_mode);
        send_byte(l16[7:0], gap_mode);
        send_byte(l16[15:8], gap_mode);

        if (len > MAX_WORDS) begin
            repeat (3) @(negedge clk);
            check({tag, "/err"}, load_err, 1);
            check({tag, "/err_ready"}, bus.in_ready, 0);
            check({tag, "/err_hold"}, cpu_hold, 1);
            check({tag, "/err_done"}, load_done, 0);
            check({tag, "/err_writes"}, obs_addr.size(), 0);
            return;
        end

        foreach (pay[i]) send_byte(pay[i], gap_mode);
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(bad_chk ? (x ^ 8'h01) : x, gap_mode);
        expect_err = bad_chk;
`else
        expect_err = 1'b0;
`endif

        n = 0;
        while (load_done !== 1'b1 && load_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);

        check({tag, "/done"}, load_done, expect_err ? 0 : 1);
        check({tag, "/err_flag"}, load_err, expect_err ? 1 : 0);
        check({tag, "/hold"}, cpu_hold, expect_err ? 1 : 0);
        check({tag, "/ready"}, bus.in_ready, 0);
        check({tag, "/word_cnt"}, word_cnt, l16);
        check({tag, "/pulse1"}, dbl_wr, 0);
        check({tag, "/n_writes"}, obs_addr.size(), exp_addr.size());
        if (obs_addr.size() == exp_addr.size()) begin
            foreach (exp_addr[i]) begin
                check({tag, "/addr"}, obs_addr[i], exp_addr[i]);
                check({tag, "/data"}, obs_data[i], exp_data[i]);
            end
        end
`ifndef IMEM_LOADER_CHKSUM_EN
        if (len > 0) check({tag, "/done_lat"}, done_cyc - last_wr_cyc, 1);
`endif
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);

        check("reset/ready", bus.in_ready, 1);
        check("reset/wr_en", bus.imem_wr_en, 0);
        check("reset/addr", bus.imem_wr_addr, 0);
        check("reset/data", bus.imem_wr_data, 0);
        check("reset/done", load_done, 0);
        check("reset/err", load_err, 0);
        check("reset/cnt", word_cnt, 0);
        check("reset/hold", cpu_hold, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Two-word directed image
        pre.delete();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("basic", 2, 0, 1'b0);

        // Garbage before sync
        pre = '{8'h00, 8'hFF, 8'h5A};
        rand_pay(1);
        run_frame("garbage", 1, 0, 1'b0);
        pre.delete();

        // Oversize length, then recovery
        pay.delete();
        run_frame("oversize", 257, 0, 1'b0);
        rand_pay(2);
        run_frame("recover", 2, 1, 1'b0);

        // in_valid toggling through a 3-word frame
        rand_pay(3);
        run_frame("toggle", 3, 2, 1'b0);

        // Empty image
        pay.delete();
        run_frame("empty", 0, 0, 1'b0);

        // Restart after 6 data bytes of a 2-word frame
        rand_pay(2);
        pulse_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
        repeat (2) @(negedge clk);
        check("mid/n_writes", obs_addr.size(), 1);
        if (obs_addr.size() == 1) begin
            check("mid/addr", obs_addr[0], 0);
            check("mid/data", obs_data[0], {pay[3], pay[2], pay[1], pay[0]});
        end
        pulse_restart();
        check("mid/hold", cpu_hold, 1);
        check("mid/cnt", word_cnt, 0);
        check("mid/ready", bus.in_ready, 1);
        repeat (4) @(negedge clk);
        check("mid/no_more", obs_addr.size(), 0);
        rand_pay(2);
        run_frame("after_mid", 2, 1, 1'b0);

`ifdef IMEM_LOADER_CHKSUM_EN
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame("chk_good", 1, 0, 1'b0);
        run_frame("chk_bad", 1, 0, 1'b1);
`endif

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            int len;
            len = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) len = int'($urandom_range(MAX_WORDS + 1, 65535));
            rand_pre(int'($urandom_range(0, 3)));
            if (len <= MAX_WORDS) rand_pay(len);
            else pay.delete();
            run_frame("rand", len, int'($urandom_range(0, 2)), 1'b0);
        end
        pre.delete();

        // Asynchronous reset mid-frame
        rand_pay(3);
        pulse_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset/cnt", word_cnt, 0);
        check("areset/wr_en", bus.imem_wr_en, 0);
        check("areset/ready", bus.in_ready, 1);
        check("areset/hold", cpu_hold, 1);
        @(negedge clk);
        reset_n = 1'b1;
        rand_pay(1);
        run_frame("post_reset", 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
